// File: rtl/pipe_stage_reg.sv
// Purpose: inter-stage pipeline register with a two-entry skid buffer, flush squash and stall counter.
// Latency: one cycle from accept to out_valid; one entry per cycle sustained while out_ready is high.
// Backpressure: in_ready is registered (!skid valid) and never depends combinationally on out_ready.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   flush                   synchronous squash of all held entries
//   in_valid/in_ready       upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready     downstream handshake, out_data/out_ctrl head entry
//   occupancy               entries held (0..2)
//   stall_cnt               saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main entry drives the outputs; skid entry only ever holds the younger entry.
    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_dat_q, main_dat_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic accept;
    logic consume;

    assign in_ready  = !skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_dat_q;
    // Stored ctrl is already zero for bubbles; the gate makes that unconditional at the port.
    assign out_ctrl  = main_vld_q ? main_ctrl_q : '0;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
    assign stall_cnt = stall_q;

    assign accept  = in_valid && in_ready;
    assign consume = main_vld_q && out_ready;

    always_comb begin
        main_vld_d  = main_vld_q;
        main_dat_d  = main_dat_q;
        main_ctrl_d = main_ctrl_q;
        skid_vld_d  = skid_vld_q;
        skid_dat_d  = skid_dat_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Redirect: drop everything, including a same-cycle accept. Data may stay stale.
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
            skid_vld_d  = 1'b0;
            skid_ctrl_d = '0;
        end else if (!main_vld_q) begin
            if (accept) begin
                main_vld_d  = 1'b1;
                main_dat_d  = in_data;
                main_ctrl_d = in_ctrl;
            end
        end else if (!skid_vld_q) begin
            if (accept && consume) begin
                main_dat_d  = in_data;
                main_ctrl_d = in_ctrl;
            end else if (accept) begin
                skid_vld_d  = 1'b1;
                skid_dat_d  = in_data;
                skid_ctrl_d = in_ctrl;
            end else if (consume) begin
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end
        end else begin
            // Full: in_ready is low so only a consume can change state.
            if (consume) begin
                main_dat_d  = skid_dat_q;
                main_ctrl_d = skid_ctrl_q;
                skid_vld_d  = 1'b0;
                skid_ctrl_d = '0;
            end
        end
    end

    // Counts the stall cycle even when a flush lands in it.
    always_comb begin
        stall_d = stall_q;
        if (main_vld_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_vld_q  <= 1'b0;
            main_dat_q  <= '0;
            main_ctrl_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_dat_q  <= '0;
            skid_ctrl_q <= '0;
            stall_q     <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_dat_q  <= main_dat_d;
            main_ctrl_q <= main_ctrl_d;
            skid_vld_q  <= skid_vld_d;
            skid_dat_q  <= skid_dat_d;
            skid_ctrl_q <= skid_ctrl_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a generic datapath bundle plus a control bundle between two pipeline stages. A two-entry skid buffer provides a full-throughput valid/ready handshake, and flush squashes in-flight control. A saturating stall counter supports performance debug.

Parameters:
DATA_W, 64, width of datapath bundle (pc, alu result, store data, etc., concatenated by the instantiator)
CTRL_W, 8, width of control bundle (RegWrite, MemRead, MemWrite, MemReg, Branch, Jump, ...); forced to zero for bubbles and on flush
CNT_W, 16, width of the stall cycle counter

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held entries (branch/jump redirect)
in_valid  input  1  upstream stage presents an entry
in_ready  output  1  block can accept an entry this cycle
in_data  input  DATA_W  upstream datapath bundle
in_ctrl  input  CTRL_W  upstream control bundle
out_valid  output  1  entry available to downstream stage
out_ready  input  1  downstream stage consumes the entry this cycle
out_data  output  DATA_W  head entry datapath bundle
out_ctrl  output  CTRL_W  head entry control; all-zero whenever out_valid=0
occupancy  output  2  entries held (0, 1 or 2)
stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (reset_n=0, asynchronous): all storage, both valid bits and stall_cnt clear. Outputs: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=1. Deassertion takes effect at the next clk edge.
- Storage: main entry (drives out_*) and skid entry. in_ready is registered: in_ready = !skid_valid. It never depends combinationally on out_ready.
- Transfer rules: accept = in_valid & in_ready. Consume = out_valid & out_ready.
- States (encoded by valid bits):
  - EMPTY (0 entries):
    - accept -> ONE; in_* captured into main.
  - ONE (1 entry):
    - accept & consume -> ONE; main reloaded from in_*.
    - accept & !consume -> TWO; in_* captured into skid.
    - !accept & consume -> EMPTY.
  - TWO (2 entries):
    - consume -> ONE; skid moves to main, skid cleared.
    - accept is impossible because in_ready=0.
- Latency: one cycle from accept to out_valid when the block was EMPTY, or ONE with a consume. Throughput is one entry per cycle while out_ready stays high.
- Ordering: strict FIFO. The skid entry is never presented ahead of main.
- Bubbles: when a valid bit is clear, the corresponding stored ctrl is zero. out_ctrl is additionally gated by out_valid. A bubble can therefore never assert RegWrite or MemWrite downstream.
- Flush: at the next edge, both valids, stored ctrl and occupancy clear, and any same-cycle accept is discarded. Flush has priority over accept and consume; a consume in that cycle still counts as taken by downstream. Data fields need not clear on flush. stall_cnt is not affected by flush.
- Stall counter: increments by 1 on every cycle with out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1 with no wrap and clears only on reset.
- Data in flight must not be modified while out_valid=1 and out_ready=0. out_data and out_ctrl are stable until consume.
- Reset mid-operation: all held entries are lost immediately and no partial state survives.
- in_data and in_ctrl are ignored when accept=0.

Test Plan:
- Reset, then stream 0x10,0x11,0x12 with out_ready=1 -> out_data = 0x10,0x11,0x12 on consecutive cycles starting one cycle after the first accept; occupancy=1 throughout; stall_cnt=0.
- Present A=0xA (ctrl=0x01) with out_ready=0, then B=0xB (ctrl=0x02) -> occupancy=2, in_ready=0, out_data=0xA held, stall_cnt counts 1,2,3. Raise out_ready -> 0xA then 0xB emerge in order, and in_ready returns to 1 the cycle after 0xA is consumed.
- With occupancy=2 (ctrl 0x3F), pulse flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, in_ready=1; the flushed-cycle input never appears at the output.
- CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays there.
- Drop reset_n asynchronously (between edges) while occupancy=2 -> out_valid, out_ctrl, occupancy and stall_cnt read 0 immediately, before the next clk edge; normal transfers resume after release.
- Random in_valid/out_ready for 10k cycles vs a scoreboard FIFO model -> no loss, no duplication, no reordering; out_ctrl=0 whenever out_valid=0.
